// File: rtl/xpb_digit_acc.sv
// Digit sequencer and residue accumulator for the xpb LUT bank: issues one 5-bit digit per cycle, sums LUT returns onto the lower word.
// Define XPB_DIGIT_ACC_CSA_EN to keep the accumulator in carry-save form and resolve it in a final RESOLVE cycle.
module xpb_digit_acc #(
    parameter int NUM_DIGITS = 16,
    parameter int DIGIT_W    = 5,
    parameter int WORD_W     = 1024,
    localparam int SUM_W     = WORD_W + $clog2(NUM_DIGITS + 1),
    localparam int SEL_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] in_upper,
    input  logic [WORD_W-1:0]             in_low,
    output logic [SEL_W-1:0]              lut_sel,
    output logic [DIGIT_W-1:0]            lut_digit,
    input  logic [WORD_W-1:0]             lut_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SUM_W-1:0]              out_sum,
    output logic [2:0]                    dbg_state_o
);

    localparam int UP_W = NUM_DIGITS * DIGIT_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid/out_sum hold until out_ready, and in_ready is high only while idle.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_DRAIN   = 3'd2,
        S_RESOLVE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [UP_W-1:0]   upper_q, upper_d;
    logic              flag_q, flag_d;
    logic              load;

    assign load        = (state_q == S_IDLE) && in_valid;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            upper_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            upper_q <= upper_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        upper_d   = upper_q;
        flag_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        lut_sel   = '0;
        lut_digit = '0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    upper_d = in_upper;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The low digit always sits at the bottom of the shift register.
                lut_sel   = idx_q;
                lut_digit = upper_q[DIGIT_W-1:0];
                flag_d    = 1'b1;
                upper_d   = upper_q >> DIGIT_W;
                idx_d     = idx_q + SEL_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
`ifdef XPB_DIGIT_ACC_CSA_EN
                state_d = S_RESOLVE;
`else
                state_d = S_DONE;
`endif
            end
            S_RESOLVE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef XPB_DIGIT_ACC_CSA_EN
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] carry_q, carry_d;
    logic [SUM_W-1:0] res_q, res_d;
    logic [SUM_W-1:0] lut_ext;

    assign lut_ext = SUM_W'(lut_data);
    assign out_sum = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            res_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            res_q   <= res_d;
        end
    end

    // 3:2 compression per return; the top carry-out is always zero because the total fits SUM_W.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        res_d   = res_q;
        if (load) begin
            sum_d   = SUM_W'(in_low);
            carry_d = '0;
        end else if (flag_q) begin
            sum_d   = sum_q ^ carry_q ^ lut_ext;
            carry_d = ((sum_q & carry_q) | (sum_q & lut_ext) | (carry_q & lut_ext)) << 1;
        end
        if (state_q == S_RESOLVE) begin
            res_d = sum_q + carry_q;
        end
    end
`else
    logic [SUM_W-1:0] acc_q, acc_d;

    assign out_sum = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = SUM_W'(in_low);
        end else if (flag_q) begin
            acc_d = acc_q + SUM_W'(lut_data);
        end
    end
`endif

endmodule

// File: tb/tb_xpb_digit_acc.sv
// Bench for xpb_digit_acc: table of operands applied through a LUT model, sums checked against an arithmetic reference.
module tb_xpb_digit_acc;

    localparam int ND   = 16;
    localparam int DW   = 5;
    localparam int WW   = 1024;
    localparam int SW   = WW + $clog2(ND + 1);
    localparam int SELW = 4;
    localparam int UW   = ND * DW;
    // Rising edges after the accept edge before out_valid is visible
    // (valid during the cycle ending at accept+NUM_DIGITS+2, one more with CSA).
`ifdef XPB_DIGIT_ACC_CSA_EN
    localparam int LAT = ND + 2;
`else
    localparam int LAT = ND + 1;
`endif
    localparam int NV = 10;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [UW-1:0]   in_upper;
    logic [WW-1:0]   in_low;
    logic [SELW-1:0] lut_sel;
    logic [DW-1:0]   lut_digit;
    logic [WW-1:0]   lut_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_sum;
    logic [2:0]      dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int lut_mode = 0;
    logic [63:0] tab [ND][32];

    xpb_digit_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_upper   (in_upper),
        .in_low     (in_low),
        .lut_sel    (lut_sel),
        .lut_digit  (lut_digit),
        .lut_data   (lut_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // LUT contents by mode: 0 = (pos+1)*digit, 1 = all-ones for nonzero digit, 2 = random table
    function automatic logic [WW-1:0] lut_fn(int mode, int p, logic [DW-1:0] d);
        case (mode)
            0: return WW'((p + 1) * int'(d));
            1: return (d != '0) ? {WW{1'b1}} : {WW{1'b0}};
            default: return {tab[p][d], {(WW-128){1'b0}}, tab[p][d]};
        endcase
    endfunction

    always @(posedge clk) lut_data <= lut_fn(lut_mode, int'(lut_sel), lut_digit);

    function automatic logic [SW-1:0] model(int mode, logic [UW-1:0] up, logic [WW-1:0] lo);
        logic [SW-1:0] s;
        s = SW'(lo);
        for (int i = 0; i < ND; i++) s = s + SW'(lut_fn(mode, i, up[i*DW +: DW]));
        return s;
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int j = 0; j < WW/32; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [UW-1:0] rand_upper();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[UW-1:0];
    endfunction

    // scoreboard check
    task automatic check(string name, logic [SW-1:0] got, logic [SW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h_%h expected %h_%h", name,
                     got[SW-1:WW-64], got[63:0], exp[SW-1:WW-64], exp[63:0]);
        end
    endtask

    typedef struct {
        logic [UW-1:0] upper;
        logic [WW-1:0] low;
        int            mode;
        int            hold;
        bit            poke;
        logic [SW-1:0] exp_sum;
    } vec_t;

    vec_t vecs [NV];

    // Called at a negedge; returns at the negedge after the output handshake.
    task automatic run_op(vec_t v);
        int k;
        bit seq_ok;
        bit stable_ok;
        logic [SW-1:0] s0;
        lut_mode = v.mode;
        in_upper = v.upper;
        in_low   = v.low;
        in_valid = 1'b1;
        check("in_ready_idle", SW'(in_ready), SW'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        k = 0;
        seq_ok = 1'b1;
        while (!out_valid && k < 64) begin
            if (k < ND) begin
                if (lut_sel !== SELW'(k) || lut_digit !== v.upper[k*DW +: DW]) seq_ok = 1'b0;
            end else if (lut_sel !== '0 || lut_digit !== '0) begin
                seq_ok = 1'b0;
            end
            if (in_ready !== 1'b0) seq_ok = 1'b0;
            if (v.poke && k == 5) begin
                in_valid = 1'b1;
                in_upper = ~v.upper;
                in_low   = ~v.low;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        check("latency", SW'(k), SW'(LAT));
        check("issue_seq", SW'(seq_ok), SW'(1));
        s0 = out_sum;
        stable_ok = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (out_sum !== s0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        if (v.hold > 0) check("hold_stable", SW'(stable_ok), SW'(1));
        check("out_sum", out_sum, v.exp_sum);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("post_handshake", SW'({out_valid, in_ready}), SW'(2'b01));
    endtask

    initial begin
        logic [WW-1:0] ones;
        bit saw_valid;
        vec_t rv;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_upper  = '0;
        in_low    = '0;
        out_ready = 1'b0;
        ones      = {WW{1'b1}};
        for (int p = 0; p < ND; p++)
            for (int d = 0; d < 32; d++) tab[p][d] = {$urandom, $urandom};

        // vector table
        vecs[0] = '{upper: '0, low: WW'(5), mode: 0, hold: 0, poke: 1'b0, exp_sum: SW'(5)};
        vecs[1] = '{upper: {ND{5'd31}}, low: '0, mode: 0, hold: 0, poke: 1'b0, exp_sum: SW'(4216)};
        vecs[2] = '{upper: {ND{5'd17}}, low: ones, mode: 1, hold: 0, poke: 1'b0,
                    exp_sum: SW'(ones) * SW'(17)};
        for (int i = 3; i < NV; i++) begin
            vecs[i].upper = rand_upper();
            vecs[i].low   = rand_word();
            vecs[i].mode  = (i % 2 == 0) ? 2 : 0;
            vecs[i].hold  = $urandom_range(0, 3);
            vecs[i].poke  = 1'b0;
        end
        vecs[3].hold = 10;
        vecs[4].upper = '0;
        vecs[4].low   = WW'(7);
        vecs[4].mode  = 0;
        vecs[4].hold  = 0;
        vecs[5].poke  = 1'b1;
        for (int i = 3; i < NV; i++) vecs[i].exp_sum = model(vecs[i].mode, vecs[i].upper, vecs[i].low);
        vecs[4].exp_sum = SW'(7);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", SW'(out_valid), SW'(0));
        check("rst_out_sum", out_sum, '0);
        check("rst_lut", SW'({lut_sel, lut_digit}), SW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", SW'(in_ready), SW'(1));

        for (int i = 0; i < NV; i++) run_op(vecs[i]);

        // reset asserted mid-ISSUE
        rv.upper = {ND{5'd9}};
        rv.low   = rand_word();
        rv.mode  = 0;
        lut_mode = 0;
        in_upper = rv.upper;
        in_low   = rv.low;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 check("pre_rst_sel", SW'({lut_sel, lut_digit}), SW'({4'd7, 5'd9}));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_lut", SW'({lut_sel, lut_digit}), SW'(0));
        check("async_rst_valid", SW'({out_valid, in_ready}), SW'(2'b01));
        check("async_rst_sum", out_sum, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("no_valid_after_rst", SW'(saw_valid), SW'(0));

        rv.upper   = rand_upper();
        rv.low     = rand_word();
        rv.mode    = 2;
        rv.hold    = 2;
        rv.poke    = 1'b0;
        rv.exp_sum = model(rv.mode, rv.upper, rv.low);
        run_op(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xpb_digit_acc.md
# xpb_digit_acc

Sequencer and accumulator downstream of the per-position xpb lookup tables in the modular-squaring reduction path. It takes the upper (overflow) word of a partial product, splits it into 5-bit digits, and issues one digit per cycle to the shared LUT bank with a position select. It accumulates each returned 1024-bit precomputed residue onto the lower word, then presents the widened sum to the next carry/compare stage through a valid/ready handshake.

## Interface
- NUM_DIGITS, 16: digits per upper word; sets the LUT position count.
- DIGIT_W, 5: bits per digit; must match the LUT address width.
- WORD_W, 1024: width of each LUT output and of the lower word.
- SUM_W, WORD_W+$clog2(NUM_DIGITS+1): derived localparam, never overridden.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request carries a new operand.
- in_ready  out  1  block can accept; high only in IDLE.
- in_upper  in  NUM_DIGITS*DIGIT_W  overflow word; digit i = bits [i*DIGIT_W +: DIGIT_W].
- in_low  in  WORD_W  lower word; initial accumulator value.
- lut_sel  out  $clog2(NUM_DIGITS)  LUT position select for the digit being issued.
- lut_digit  out  DIGIT_W  digit driven to the LUT data_in.
- lut_data  in  WORD_W  registered LUT output; valid exactly one cycle after issue.
- out_valid  out  1  sum valid; held until accepted.
- out_ready  in  1  consumer accepts.
- out_sum  out  SUM_W  in_low + sum of all LUT returns.

## Operation
- States: IDLE, ISSUE, DRAIN, RESOLVE (CSA build only), DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_upper into a shift register, load acc=zero-extended in_low, set idx=0, go to ISSUE.
- ISSUE: drive lut_sel=idx and lut_digit=digit idx, low digit first; idx increments each cycle. A one-bit pipeline flag marks the LUT return one cycle later. After idx=NUM_DIGITS-1 is issued, go to DRAIN.
- Every cycle the flag is set, acc += zero-extended lut_data. Accumulation overlaps issue.
- DRAIN: absorb the last LUT return. Go to DONE, or to RESOLVE in the CSA build.
- DONE: out_valid=1, out_sum=acc stable. On out_ready, return to IDLE. Back-to-back starts are allowed the cycle after the handshake.
- Zero digits are still issued; the LUT returns 0, so they do not shorten latency.
- Arithmetic: unsigned, no modular reduction here. SUM_W holds worst case (NUM_DIGITS+1)*(2^WORD_W-1). Overflow is impossible and is not flagged.
- in_valid while not IDLE is ignored; in_ready=0 stalls the producer.
- lut_sel and lut_digit are 0 outside ISSUE.
- Reset mid-operation: rst_n low clears state to IDLE, acc, idx, and flag immediately. The in-flight result is discarded and no out_valid is produced.

## Timing
- Reset values: in_ready=1 (after release), out_valid=0, out_sum=0, lut_sel=0, lut_digit=0.
- Accept edge T. Digit i is issued in cycle T+1+i. Its LUT data is added at edge T+2+i.
- Base build: out_valid rises at T+NUM_DIGITS+2, which is 18 for the defaults.
- CSA build: out_valid rises one cycle later, at T+NUM_DIGITS+3.
- Result held indefinitely under out_ready=0.
- Throughput: one operand per NUM_DIGITS+3 cycles (base) with out_ready tied high.

## Configuration
- XPB_DIGIT_ACC_CSA_EN defined: acc is a sum/carry pair updated with a 3:2 compressor, with no carry chain in ISSUE/DRAIN. RESOLVE performs one full carry-propagate add into out_sum, adding one cycle of latency.
- Undefined: acc is a single SUM_W register using a ripple/inferred adder each cycle. There is no RESOLVE state.
- out_sum is bit-identical in both builds.

## Test plan
- Bench LUT model returns (position+1)*digit, registered. in_upper all digits 0, in_low=5 -> out_sum=5, out_valid at T+18 (T+19 CSA).
- All digits 31, in_low=0 -> out_sum=31*136=4216. lut_sel steps 0..15 on consecutive cycles T+1..T+16.
- Bench LUT returns 2^1024-1 for any nonzero digit; all digits nonzero, in_low=2^1024-1 -> out_sum=17*(2^1024-1). Checks the top SUM_W bits.
- out_ready low for 10 cycles after out_valid -> out_sum stable and in_ready=0 throughout. Second operand (in_low=7, digits 0) accepted the cycle after the handshake -> out_sum=7.
- in_valid pulsed during ISSUE with different data -> ignored; first result unchanged.
- rst_n asserted at T+8 mid-ISSUE -> outputs return to reset values asynchronously with no out_valid. A new operand after release completes normally.
